// File: rtl/c86_membus.sv
// c86_membus: adapts the c86 core byte bus to a 16-bit asynchronous SRAM.
// Latency: WAIT+3 clocks per transfer (ISSUE 1, STROBE WAIT+1, ACK 1); 2 clocks on a read-buffer hit.
// Backpressure: the core is throttled through cpu_ce, high for one clock per completed access.
// Optional feature: define C86_MEMBUS_WBUF_EN for a one-word read buffer (write-through).
// Ports:
//   clock, rst_n          : clock, synchronous active-low reset
//   cpu_a/cpu_o/cpu_w     : core byte address, write data, write request (sampled in ISSUE)
//   cpu_i, cpu_ce         : registered read data and clock enable back to the core
//   sram_a, sram_dq_o/_oe : word address, replicated write byte, pad drive enable
//   sram_dq_i             : read data from the pads
//   sram_*_n              : chip/output/write strobes and byte lanes, all active low
module c86_membus #(
   parameter int WAIT = 2
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic [19:0] cpu_a,
   input  logic [7:0]  cpu_o,
   input  logic        cpu_w,
   output logic [7:0]  cpu_i,
   output logic        cpu_ce,
   output logic [18:0] sram_a,
   output logic [15:0] sram_dq_o,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_i,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n
);

   localparam logic [3:0] WAIT_CNT = 4'(WAIT);

   typedef enum logic [1:0] {ISSUE, STROBE, ACK} state_t;

   state_t      state, state_d;
   logic [3:0]  cnt, cnt_d;
   logic        req_a0, req_a0_d;
   logic        req_w, req_w_d;
   logic [7:0]  cpu_i_d;
   logic        cpu_ce_d;
   logic [18:0] sram_a_d;
   logic [15:0] sram_dq_o_d;
   logic        dq_oe_d, ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d;

   logic        hit;
   logic [7:0]  hit_dat;
   logic        strobe_done;

   // Last STROBE clock: read data is sampled and strobes released on this edge.
   assign strobe_done = (state == STROBE) && (cnt == 4'd0);

`ifdef C86_MEMBUS_WBUF_EN
   logic        buf_vld;
   logic [18:0] buf_tag;
   logic [15:0] buf_dat;

   assign hit     = !cpu_w && buf_vld && (buf_tag == cpu_a[19:1]);
   assign hit_dat = cpu_a[0] ? buf_dat[15:8] : buf_dat[7:0];

   // Every read refills the whole word; writes pass through to SRAM and
   // patch the buffered byte only when they land on the tagged word.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         buf_vld <= 1'b0;
         buf_tag <= '0;
         buf_dat <= '0;
      end else if (strobe_done) begin
         if (!req_w) begin
            buf_vld <= 1'b1;
            buf_tag <= sram_a;
            buf_dat <= sram_dq_i;
         end else if (buf_vld && (buf_tag == sram_a)) begin
            if (req_a0) buf_dat[15:8] <= sram_dq_o[15:8];
            else        buf_dat[7:0]  <= sram_dq_o[7:0];
         end
      end
   end
`else
   assign hit     = 1'b0;
   assign hit_dat = 8'h00;
`endif

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state      <= ISSUE;
         cnt        <= 4'd0;
         req_a0     <= 1'b0;
         req_w      <= 1'b0;
         cpu_i      <= 8'h00;
         cpu_ce     <= 1'b0;
         sram_a     <= '0;
         sram_dq_o  <= '0;
         sram_dq_oe <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_ub_n  <= 1'b1;
         sram_lb_n  <= 1'b1;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         req_a0     <= req_a0_d;
         req_w      <= req_w_d;
         cpu_i      <= cpu_i_d;
         cpu_ce     <= cpu_ce_d;
         sram_a     <= sram_a_d;
         sram_dq_o  <= sram_dq_o_d;
         sram_dq_oe <= dq_oe_d;
         sram_ce_n  <= ce_n_d;
         sram_oe_n  <= oe_n_d;
         sram_we_n  <= we_n_d;
         sram_ub_n  <= ub_n_d;
         sram_lb_n  <= lb_n_d;
      end
   end

   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      req_a0_d    = req_a0;
      req_w_d     = req_w;
      cpu_i_d     = cpu_i;
      cpu_ce_d    = cpu_ce;
      sram_a_d    = sram_a;
      sram_dq_o_d = sram_dq_o;
      dq_oe_d     = sram_dq_oe;
      ce_n_d      = sram_ce_n;
      oe_n_d      = sram_oe_n;
      we_n_d      = sram_we_n;
      ub_n_d      = sram_ub_n;
      lb_n_d      = sram_lb_n;
      case (state)
         ISSUE: begin
            // Request is captured here so the core may change its bus during STROBE.
            sram_a_d    = cpu_a[19:1];
            req_a0_d    = cpu_a[0];
            req_w_d     = cpu_w;
            sram_dq_o_d = {cpu_o, cpu_o};
            cnt_d       = WAIT_CNT;
            if (hit) begin
               cpu_i_d  = hit_dat;
               cpu_ce_d = 1'b1;
               state_d  = ACK;
            end else begin
               ce_n_d  = 1'b0;
               oe_n_d  = cpu_w;
               we_n_d  = !cpu_w;
               dq_oe_d = cpu_w;
               ub_n_d  = !cpu_a[0];
               lb_n_d  = cpu_a[0];
               state_d = STROBE;
            end
         end
         STROBE: begin
            if (cnt == 4'd0) begin
               if (req_w)       cpu_i_d = sram_dq_o[7:0];
               else if (req_a0) cpu_i_d = sram_dq_i[15:8];
               else             cpu_i_d = sram_dq_i[7:0];
               ce_n_d   = 1'b1;
               oe_n_d   = 1'b1;
               we_n_d   = 1'b1;
               ub_n_d   = 1'b1;
               lb_n_d   = 1'b1;
               dq_oe_d  = 1'b0;
               cpu_ce_d = 1'b1;
               state_d  = ACK;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end
         ACK: begin
            cpu_ce_d = 1'b0;
            state_d  = ISSUE;
         end
         default: state_d = ISSUE;
      endcase
   end

endmodule

// File: tb/tb_c86_membus.sv
// tb_c86_membus: directed checks of c86_membus against a behavioural SRAM.
// Main instance uses WAIT=2; two side instances (WAIT=0, WAIT=15) measure transfer period.
// Expectations follow C86_MEMBUS_WBUF_EN when the bench is built with it.
module tb_c86_membus;

   localparam int W    = 2;
   localparam int FULL = W + 3;
`ifdef C86_MEMBUS_WBUF_EN
   localparam int HITC = 2;
`else
   localparam int HITC = FULL;
`endif

   logic        clock;
   logic        rst_n;
   logic [19:0] cpu_a;
   logic [7:0]  cpu_o;
   logic        cpu_w;
   logic [7:0]  cpu_i;
   logic        cpu_ce;
   logic [18:0] sram_a;
   logic [15:0] sram_dq_o;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_i;
   logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:(1<<19)-1];
   logic [15:0] junk;
   bit          pre_done = 1'b0;
   bit          ce_prev  = 1'b0;
   int          dbl      = 0;

   // side instances
   logic        x_rst [2];
   logic [19:0] x_a   [2];
   logic [7:0]  x_o   [2];
   logic        x_w   [2];
   logic [7:0]  x_i   [2];
   logic        x_ce  [2];
   logic [18:0] x_sa  [2];
   logic [15:0] x_so  [2];
   logic        x_soe [2];
   logic        x_cen [2], x_oen [2], x_wen [2], x_ubn [2], x_lbn [2];
   bit          x_done [2];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   c86_membus #(.WAIT(W)) u_dut (
      .clock(clock), .rst_n(rst_n), .cpu_a(cpu_a), .cpu_o(cpu_o), .cpu_w(cpu_w),
      .cpu_i(cpu_i), .cpu_ce(cpu_ce), .sram_a(sram_a), .sram_dq_o(sram_dq_o),
      .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n),
      .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
   );

   c86_membus #(.WAIT(0)) u_w0 (
      .clock(clock), .rst_n(x_rst[0]), .cpu_a(x_a[0]), .cpu_o(x_o[0]), .cpu_w(x_w[0]),
      .cpu_i(x_i[0]), .cpu_ce(x_ce[0]), .sram_a(x_sa[0]), .sram_dq_o(x_so[0]),
      .sram_dq_oe(x_soe[0]), .sram_dq_i(junk), .sram_ce_n(x_cen[0]),
      .sram_oe_n(x_oen[0]), .sram_we_n(x_wen[0]), .sram_ub_n(x_ubn[0]), .sram_lb_n(x_lbn[0])
   );

   c86_membus #(.WAIT(15)) u_w15 (
      .clock(clock), .rst_n(x_rst[1]), .cpu_a(x_a[1]), .cpu_o(x_o[1]), .cpu_w(x_w[1]),
      .cpu_i(x_i[1]), .cpu_ce(x_ce[1]), .sram_a(x_sa[1]), .sram_dq_o(x_so[1]),
      .sram_dq_oe(x_soe[1]), .sram_dq_i(junk), .sram_ce_n(x_cen[1]),
      .sram_oe_n(x_oen[1]), .sram_we_n(x_wen[1]), .sram_ub_n(x_ubn[1]), .sram_lb_n(x_lbn[1])
   );

   // Behavioural async SRAM: drives stored word while chip+output enabled, garbage otherwise.
   assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : junk;

   always @(negedge clock) junk = 16'($urandom);

   always @(posedge clock) begin
      if (!pre_done) begin
         mem[19'h7F800] <= 16'hA55A;
         mem[19'h7FFFF] <= 16'hC300;
         mem[19'h00010] <= 16'h1234;
         mem[19'h091A2] <= 16'hBEEF;
         pre_done       <= 1'b1;
      end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
         if (!sram_lb_n) mem[sram_a][7:0]  <= sram_dq_o[7:0];
         if (!sram_ub_n) mem[sram_a][15:8] <= sram_dq_o[15:8];
      end
   end

   always @(negedge clock) begin
      if (cpu_ce && ce_prev) dbl++;
      ce_prev = cpu_ce;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One core transfer starting from an ACK clock (or reset release); ends on the cpu_ce clock.
   task automatic xfer(input string tag, input logic [19:0] a, input logic [7:0] o,
                       input logic w, input bit scr, input int exp_cyc, input logic [7:0] exp_d);
      int          cyc = 0, oe = 0, we = 0, bad = 0, exp_str;
      bit          seen = 1'b0;
      logic [1:0]  lanes = 2'b11;
      logic [18:0] fa = '0;
      logic [15:0] fdo = '0;
      logic        foe = 1'b0;
      cpu_a = a; cpu_o = o; cpu_w = w;
      do begin
         tick();
         cyc++;
         if (!sram_ce_n) begin
            if (!seen) begin
               seen = 1'b1;
               lanes = {sram_ub_n, sram_lb_n};
               fa = sram_a; fdo = sram_dq_o; foe = sram_dq_oe;
               if (scr) begin cpu_a = ~a; cpu_o = ~o; cpu_w = ~w; end
            end else if (sram_a != fa || sram_dq_o != fdo || sram_dq_oe != foe ||
                         {sram_ub_n, sram_lb_n} != lanes) begin
               bad++;
            end
            if (!sram_oe_n) oe++;
            if (!sram_we_n) we++;
         end
      end while (!cpu_ce && cyc < 40);
      exp_str = (exp_cyc == 2) ? 0 : W + 1;
      check({tag, "_cyc"}, cyc, exp_cyc);
      check({tag, "_data"}, cpu_i, exp_d);
      check({tag, "_oe_clks"}, oe, w ? 0 : exp_str);
      check({tag, "_we_clks"}, we, w ? exp_str : 0);
      check({tag, "_stable"}, bad, 0);
      if (exp_str == 0) begin
         check({tag, "_lanes"}, lanes, 2'b11);
      end else begin
         check({tag, "_lanes"}, lanes, a[0] ? 2'b01 : 2'b10);
         check({tag, "_addr"}, fa, a[19:1]);
         check({tag, "_dq_oe"}, foe, w);
         if (w) check({tag, "_dq_o"}, fdo, {o, o});
      end
      check({tag, "_ack_strb"}, {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'h1F);
   endtask

   task automatic period_run(input int k, input int wt);
      int cyc, bad = 0, total = 0;
      x_rst[k] = 1'b0; x_a[k] = '0; x_o[k] = '0; x_w[k] = 1'b0;
      repeat (3) tick();
      x_rst[k] = 1'b1;
      cyc = 0;
      do begin tick(); cyc++; end while (!x_ce[k] && cyc < 40);
      check($sformatf("w%0d_first", wt), cyc, wt + 2);
      for (int i = 1; i <= 100; i++) begin
         // consecutive transfers touch distinct words so a buffer never hits
         x_a[k] = {i[18:0], 1'($urandom)};
         x_o[k] = 8'($urandom);
         x_w[k] = 1'($urandom);
         cyc = 0;
         do begin tick(); cyc++; total++; end while (!x_ce[k] && cyc < 40);
         if (cyc != wt + 3) bad++;
      end
      check($sformatf("w%0d_period_bad", wt), bad, 0);
      check($sformatf("w%0d_total_clks", wt), total, 100 * (wt + 3));
      x_done[k] = 1'b1;
   endtask

   initial period_run(0, 0);
   initial period_run(1, 15);

   initial begin
      bit ce_seen = 1'b0;
      rst_n = 1'b0; cpu_a = 20'hFF001; cpu_o = 8'h00; cpu_w = 1'b0;
      repeat (3) tick();
      check("rst_ce", cpu_ce, 1'b0);
      check("rst_cpu_i", cpu_i, 8'h00);
      check("rst_strb", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'h1F);
      check("rst_dq_oe", sram_dq_oe, 1'b0);
      check("rst_addr", sram_a, 19'h0);
      check("rst_dq_o", sram_dq_o, 16'h0);

      rst_n = 1'b1;
      xfer("rd_odd",  20'hFF001, 8'h00, 1'b0, 1'b0, W + 2, 8'hA5);
      xfer("rd_even", 20'hFF000, 8'h00, 1'b0, 1'b0, HITC,  8'h5A);
      xfer("wr",      20'h00002, 8'h3C, 1'b1, 1'b0, FULL,  8'h3C);
      check("wr_mem", mem[1][7:0], 8'h3C);
      xfer("rd_wr",   20'h00002, 8'h00, 1'b0, 1'b0, FULL,  8'h3C);
      xfer("rd_top",  20'hFFFFF, 8'h00, 1'b0, 1'b0, FULL,  8'hC3);
      xfer("rd_scr",  20'h00021, 8'h55, 1'b0, 1'b1, FULL,  8'h12);
      xfer("rd_pre",  20'h12344, 8'h00, 1'b0, 1'b0, FULL,  8'hEF);

      // reset on the second STROBE clock of a write
      cpu_a = 20'h00040; cpu_o = 8'h99; cpu_w = 1'b1;
      tick();
      check("mr_issue_ce", cpu_ce, 1'b0);
      tick();
      tick();
      check("mr_we_low", sram_we_n, 1'b0);
      rst_n = 1'b0;
      tick();
      check("mr_strb", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'h1F);
      check("mr_dq_oe", sram_dq_oe, 1'b0);
      check("mr_ce", cpu_ce, 1'b0);
      check("mr_cpu_i", cpu_i, 8'h00);
      check("mr_addr", sram_a, 19'h0);
      ce_seen = cpu_ce;
      tick();
      ce_seen = ce_seen | cpu_ce;
      check("mr_no_ce", ce_seen, 1'b0);

      rst_n = 1'b1;
      xfer("rd_rst",  20'h12345, 8'h00, 1'b0, 1'b0, W + 2, 8'hBE);
      xfer("rd_hit",  20'h12344, 8'h00, 1'b0, 1'b0, HITC,  8'hEF);
      xfer("wr_hit",  20'h12344, 8'h77, 1'b1, 1'b0, FULL,  8'h77);
      xfer("rd_upd",  20'h12344, 8'h00, 1'b0, 1'b0, HITC,  8'h77);

      for (int n = 0; n < 4000 && !(x_done[0] && x_done[1]); n++) tick();
      check("side_done", {x_done[0], x_done[1]}, 2'b11);
      check("ce_double", dbl, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
